// File: rtl/idu_pkg.sv
// Shared encodings for the IDU decode stage: ALU/immediate/branch codes,
// RV opcodes, the ebreak word, the decoded control bundle and the FSM states.
package idu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_COPYB = 4'd10;

  localparam logic [2:0] EXT_NONE = 3'd0;
  localparam logic [2:0] EXT_R    = 3'd1;
  localparam logic [2:0] EXT_I    = 3'd2;
  localparam logic [2:0] EXT_S    = 3'd3;
  localparam logic [2:0] EXT_B    = 3'd4;
  localparam logic [2:0] EXT_U    = 3'd5;
  localparam logic [2:0] EXT_J    = 3'd6;

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_COND = 3'd1;
  localparam logic [2:0] BR_JAL  = 3'd2;
  localparam logic [2:0] BR_JALR = 3'd3;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [31:0] INST_EBREAK = 32'h00100073;

  typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} idu_state_e;

  typedef struct packed {
    logic [3:0] aluct;
    logic [2:0] extop;
    logic       regwr;
    logic       alu_asr;
    logic       alu_bsr;
    logic       mem_rd;
    logic       mem_wr;
    logic [2:0] mem_op;
    logic [2:0] branch;
    logic       word;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       illegal;
  } idu_ctrl_t;

  // alt selects SUB over ADD (funct3=0) and SRA over SRL (funct3=5).
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/idu_decode_comb.sv
// Combinational RV32I/RV64I instruction-to-control decode, parameterised on XLEN.
module idu_decode_comb
  import idu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0] inst_i,
  output idu_ctrl_t   ctrl_o
);

  localparam bit IS_RV32 = (XLEN == 32);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       ill;
  logic       word_v;
  logic       alt_v;
  logic       f3_w_ok;

  assign opcode  = inst_i[6:0];
  assign f3      = inst_i[14:12];
  assign f7      = inst_i[31:25];
  assign f3_w_ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd5);

  always_comb begin
    ctrl_o     = '0;
    ill        = 1'b0;
    word_v     = 1'b0;
    alt_v      = 1'b0;
    ctrl_o.rd  = inst_i[11:7];
    ctrl_o.rs1 = inst_i[19:15];
    ctrl_o.rs2 = inst_i[24:20];
    case (opcode)
      OPC_LUI: begin
        ctrl_o.aluct = ALU_COPYB; ctrl_o.extop = EXT_U;
        ctrl_o.regwr = 1'b1;      ctrl_o.alu_bsr = 1'b1;
      end
      OPC_AUIPC: begin
        ctrl_o.aluct = ALU_ADD;   ctrl_o.extop = EXT_U;
        ctrl_o.regwr = 1'b1;      ctrl_o.alu_bsr = 1'b1;
      end
      OPC_JAL: begin
        ctrl_o.aluct = ALU_ADD;   ctrl_o.extop = EXT_J;
        ctrl_o.regwr = 1'b1;      ctrl_o.alu_bsr = 1'b1;
        ctrl_o.branch = BR_JAL;
      end
      OPC_JALR: begin
        ctrl_o.aluct = ALU_ADD;   ctrl_o.extop = EXT_I;
        ctrl_o.regwr = 1'b1;      ctrl_o.alu_asr = 1'b1; ctrl_o.alu_bsr = 1'b1;
        ctrl_o.branch = BR_JALR;
      end
      OPC_BRANCH: begin
        // beq/bne compare by subtraction, blt/bge by SLT, bltu/bgeu by SLTU.
        ctrl_o.aluct = !f3[2] ? ALU_SUB : (f3[1] ? ALU_SLTU : ALU_SLT);
        ctrl_o.extop = EXT_B;     ctrl_o.alu_asr = 1'b1;
        ctrl_o.branch = BR_COND;
      end
      OPC_LOAD: begin
        ctrl_o.aluct = ALU_ADD;   ctrl_o.extop = EXT_I;
        ctrl_o.regwr = 1'b1;      ctrl_o.alu_asr = 1'b1; ctrl_o.alu_bsr = 1'b1;
        ctrl_o.mem_rd = 1'b1;     ctrl_o.mem_op = f3;
      end
      OPC_STORE: begin
        ctrl_o.aluct = ALU_ADD;   ctrl_o.extop = EXT_S;
        ctrl_o.alu_asr = 1'b1;    ctrl_o.alu_bsr = 1'b1;
        ctrl_o.mem_wr = 1'b1;     ctrl_o.mem_op = f3;
      end
      OPC_OP_IMM, OPC_OP_IMM32: begin
        word_v = (opcode == OPC_OP_IMM32);
        ctrl_o.aluct = alu_from_f3(f3, (f3 == 3'd5) && inst_i[30]);
        ctrl_o.extop = EXT_I;     ctrl_o.regwr = 1'b1;
        ctrl_o.alu_asr = 1'b1;    ctrl_o.alu_bsr = 1'b1;
        if (word_v && (IS_RV32 || !f3_w_ok)) ill = 1'b1;
        if ((f3 == 3'd1) && (inst_i[31:26] != 6'b000000)) ill = 1'b1;
        if ((f3 == 3'd5) && (inst_i[31:26] != 6'b000000) && (inst_i[31:26] != 6'b010000)) ill = 1'b1;
        // shamt[5] only exists for full-width shifts on RV64.
        if (((f3 == 3'd1) || (f3 == 3'd5)) && inst_i[25] && (IS_RV32 || word_v)) ill = 1'b1;
      end
      OPC_OP, OPC_OP32: begin
        word_v = (opcode == OPC_OP32);
        alt_v  = (f7 == 7'b0100000);
        ctrl_o.aluct = alu_from_f3(f3, alt_v);
        ctrl_o.extop = EXT_R;     ctrl_o.regwr = 1'b1;
        ctrl_o.alu_asr = 1'b1;
        if (!((f7 == 7'b0000000) || (alt_v && ((f3 == 3'd0) || (f3 == 3'd5))))) ill = 1'b1;
        if (word_v && (IS_RV32 || !f3_w_ok)) ill = 1'b1;
      end
      OPC_MISC_MEM: begin
        ctrl_o.extop = EXT_NONE;
      end
      OPC_SYSTEM: begin
        ctrl_o.aluct = ALU_ADD;   ctrl_o.extop = EXT_I;
        ctrl_o.alu_asr = 1'b1;    ctrl_o.alu_bsr = 1'b1;
      end
      default: ill = 1'b1;
    endcase
    ctrl_o.word = word_v && !IS_RV32;
    if (ill) begin
      ctrl_o.regwr  = 1'b0;
      ctrl_o.mem_rd = 1'b0;
      ctrl_o.mem_wr = 1'b0;
      ctrl_o.branch = BR_NONE;
      ctrl_o.word   = 1'b0;
    end
    ctrl_o.illegal = ill;
  end

endmodule

// File: rtl/idu_decode_stage.sv
// Registered decode stage: valid/ready input, one bundle register, flush, ebreak HALT FSM.
// Optional perf counters under `define IDU_DECODE_PERF_EN.
module idu_decode_stage
  import idu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ALUCT_W = 4,
  parameter int EXTOP_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_inst,
  input  logic [XLEN-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_pc,
  output logic [ALUCT_W-1:0] ALUct,
  output logic [EXTOP_W-1:0] Extop,
  output logic               RegWr,
  output logic               ALUAsr,
  output logic               ALUBsr,
  output logic               MemRd,
  output logic               MemWr,
  output logic [2:0]         MemOp,
  output logic [2:0]         Branch,
  output logic               Word,
  output logic [4:0]         rd,
  output logic [4:0]         rs1,
  output logic [4:0]         rs2,
  output logic               illegal,
  input  logic               flush,
  output logic               halt,
  input  logic               resume
`ifdef IDU_DECODE_PERF_EN
  ,
  output logic [31:0]        perf_inst,
  output logic [31:0]        perf_illegal
`endif
);

  // Handshake: a transfer happens on a cycle where in_valid && in_ready; the
  // bundle is held while out_valid && !out_ready and retires when out_ready is high.
  idu_state_e          state_q, state_d;
  logic                out_valid_q, out_valid_d;
  idu_ctrl_t           ctrl_q, ctrl_d, dec;
  logic [XLEN-1:0]     pc_q, pc_d;
  logic                xfer, accept;

  idu_decode_comb #(.XLEN(XLEN)) u_dec (
    .inst_i (in_inst),
    .ctrl_o (dec)
  );

  assign in_ready = (state_q == ST_RUN) && (!out_valid_q || out_ready);
  assign xfer     = in_valid && in_ready;
  assign accept   = xfer && !flush;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    ctrl_d      = ctrl_q;
    pc_d        = pc_q;
    case (state_q)
      ST_RUN:  if (accept && (in_inst == INST_EBREAK)) state_d = ST_HALT;
      ST_HALT: if (resume) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (xfer) begin
      out_valid_d = 1'b1;
      ctrl_d      = dec;
      pc_d        = in_pc;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      pc_q        <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      ctrl_q      <= ctrl_d;
      pc_q        <= pc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pc    = pc_q;
  assign ALUct     = ALUCT_W'(ctrl_q.aluct);
  assign Extop     = EXTOP_W'(ctrl_q.extop);
  assign RegWr     = ctrl_q.regwr;
  assign ALUAsr    = ctrl_q.alu_asr;
  assign ALUBsr    = ctrl_q.alu_bsr;
  assign MemRd     = ctrl_q.mem_rd;
  assign MemWr     = ctrl_q.mem_wr;
  assign MemOp     = ctrl_q.mem_op;
  assign Branch    = ctrl_q.branch;
  assign Word      = ctrl_q.word;
  assign rd        = ctrl_q.rd;
  assign rs1       = ctrl_q.rs1;
  assign rs2       = ctrl_q.rs2;
  assign illegal   = ctrl_q.illegal;
  // halt is a direct view of the FSM state.
  assign halt      = (state_q == ST_HALT);

`ifdef IDU_DECODE_PERF_EN
  logic [31:0] perf_inst_q, perf_illegal_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_inst_q    <= '0;
      perf_illegal_q <= '0;
    end else if (accept) begin
      perf_inst_q    <= perf_inst_q + 32'd1;
      perf_illegal_q <= perf_illegal_q + {31'd0, dec.illegal};
    end
  end

  assign perf_inst    = perf_inst_q;
  assign perf_illegal = perf_illegal_q;
`endif

endmodule

// File: tb/tb_idu_decode_stage.sv
// Directed bench for idu_decode_stage: an RV32 and an RV64 instance share stimulus;
// expected bundles go to a queue when driven and are popped when out_valid appears.
module tb_idu_decode_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, flush, resume;
  logic [31:0] in_inst, in_pc;
  always #5 clk = ~clk;

  logic        in_ready, out_valid, RegWr, ALUAsr, ALUBsr, MemRd, MemWr, Word, illegal, halt;
  logic [31:0] out_pc;
  logic [3:0]  ALUct;
  logic [2:0]  Extop, MemOp, Branch;
  logic [4:0]  rd, rs1, rs2;

  logic        in_ready_w, out_valid_w, RegWr_w, ALUAsr_w, ALUBsr_w, MemRd_w, MemWr_w, Word_w, illegal_w, halt_w;
  logic [63:0] out_pc_w;
  logic [3:0]  ALUct_w;
  logic [2:0]  Extop_w, MemOp_w, Branch_w;
  logic [4:0]  rd_w, rs1_w, rs2_w;
`ifdef IDU_DECODE_PERF_EN
  logic [31:0] perf_inst, perf_illegal, perf_inst_w, perf_illegal_w;
`endif

  idu_decode_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .ALUct(ALUct), .Extop(Extop), .RegWr(RegWr), .ALUAsr(ALUAsr), .ALUBsr(ALUBsr),
    .MemRd(MemRd), .MemWr(MemWr), .MemOp(MemOp), .Branch(Branch), .Word(Word),
    .rd(rd), .rs1(rs1), .rs2(rs2), .illegal(illegal), .flush(flush), .halt(halt),
    .resume(resume)
`ifdef IDU_DECODE_PERF_EN
    , .perf_inst(perf_inst), .perf_illegal(perf_illegal)
`endif
  );

  idu_decode_stage #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w), .in_inst(in_inst),
    .in_pc({32'h0, in_pc}), .out_valid(out_valid_w), .out_ready(out_ready), .out_pc(out_pc_w),
    .ALUct(ALUct_w), .Extop(Extop_w), .RegWr(RegWr_w), .ALUAsr(ALUAsr_w), .ALUBsr(ALUBsr_w),
    .MemRd(MemRd_w), .MemWr(MemWr_w), .MemOp(MemOp_w), .Branch(Branch_w), .Word(Word_w),
    .rd(rd_w), .rs1(rs1_w), .rs2(rs2_w), .illegal(illegal_w), .flush(flush), .halt(halt_w),
    .resume(resume)
`ifdef IDU_DECODE_PERF_EN
    , .perf_inst(perf_inst_w), .perf_illegal(perf_illegal_w)
`endif
  );

  logic [66:0] obs, obs64;
  assign obs   = {out_pc, ALUct, Extop, RegWr, ALUAsr, ALUBsr, MemRd, MemWr, MemOp, Branch,
                  Word, rd, rs1, rs2, illegal};
  assign obs64 = {out_pc_w[31:0], ALUct_w, Extop_w, RegWr_w, ALUAsr_w, ALUBsr_w, MemRd_w,
                  MemWr_w, MemOp_w, Branch_w, Word_w, rd_w, rs1_w, rs2_w, illegal_w};

  int          total = 0;
  int          bad   = 0;
  logic [66:0] exp_q[$];

  function automatic logic [66:0] mk(input logic [31:0] pc, input logic [3:0] alu,
      input logic [2:0] ext, input logic rw, input logic asr, input logic bsr,
      input logic mrd, input logic mwr, input logic [2:0] mop, input logic [2:0] br,
      input logic wd, input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
      input logic ill);
    return {pc, alu, ext, rw, asr, bsr, mrd, mwr, mop, br, wd, d, s1, s2, ill};
  endfunction

  task automatic chk(input string tag, input logic [66:0] o, input logic [66:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic sb_check(input string tag);
    chk({tag, "_qnonempty"}, 67'(exp_q.size() != 0), 67'd1);
    if (exp_q.size() != 0) begin
      chk({tag, "_valid"}, 67'(out_valid), 67'd1);
      chk(tag, obs, exp_q.pop_front());
    end
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc,
                       input logic push, input logic [66:0] e);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    if (push) exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] I_ADDI  = 32'h00510093;
  localparam logic [31:0] I_SUB   = 32'h405201B3;
  localparam logic [31:0] I_OR    = 32'h0083E333;
  localparam logic [31:0] I_ADDIW = 32'h0010809B;
  localparam logic [31:0] I_SLLI  = 32'h02009093;
  localparam logic [31:0] I_MUL   = 32'h022081B3;
  localparam logic [31:0] I_LW    = 32'h0000A103;
  localparam logic [31:0] I_EBRK  = 32'h00100073;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] tbl_inst[6];
    logic [66:0] tbl_exp[6];
    logic [66:0] e_sub;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0; resume = 1'b0;
    in_inst = '0; in_pc = '0;
    tick(); tick();
    chk("rst_valid", 67'(out_valid), 67'd0);
    chk("rst_halt", 67'(halt), 67'd0);
    chk("rst_bundle", obs, 67'd0);
    rst = 1'b0;
    chk("rst_in_ready", 67'(in_ready), 67'd1);

    // addi x1,x2,5
    drive(I_ADDI, 32'h100, 1'b1, mk(32'h100, 0, 2, 1, 1, 1, 0, 0, 0, 0, 0, 1, 2, 5, 0));
    tick();
    in_valid = 1'b0;
    sb_check("addi");
    tick();
    chk("addi_drop", 67'(out_valid), 67'd0);

    // sub held under backpressure while "or" waits at the input
    out_ready = 1'b0;
    e_sub = mk(32'h104, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 3, 4, 5, 0);
    drive(I_SUB, 32'h104, 1'b1, e_sub);
    tick();
    sb_check("sub");
    drive(I_OR, 32'h108, 1'b1, mk(32'h108, 8, 1, 1, 1, 0, 0, 0, 0, 0, 0, 6, 7, 8, 0));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_in_ready", 67'(in_ready), 67'd0);
      chk("stall_hold", obs, e_sub);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    sb_check("or");
    tick();
    chk("or_drop", 67'(out_valid), 67'd0);

    // RV64-only forms and illegal encodings
    drive(I_ADDIW, 32'h200, 1'b0, '0);
    tick();
    chk("addiw32_illegal", 67'(illegal), 67'd1);
    chk("addiw32_ctl", 67'({RegWr, MemRd, MemWr, Branch, Word}), 67'd0);
    chk("addiw64", obs64, mk(32'h200, 0, 2, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 0));
    drive(I_SLLI, 32'h204, 1'b0, '0);
    tick();
    chk("slli32_illegal", 67'({illegal, RegWr}), 67'b10);
    chk("slli64", obs64, mk(32'h204, 2, 2, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    drive(I_MUL, 32'h208, 1'b0, '0);
    tick();
    in_valid = 1'b0;
    chk("mul32_illegal", 67'({illegal, RegWr}), 67'b10);
    chk("mul64_illegal", 67'({illegal_w, RegWr_w}), 67'b10);
    tick();

    // back-to-back legal instructions across formats
    tbl_inst[0] = I_LW;         tbl_exp[0] = mk(32'h300, 0, 2, 1, 1, 1, 1, 0, 2, 0, 0, 2, 1, 0, 0);
    tbl_inst[1] = 32'h00512423; tbl_exp[1] = mk(32'h304, 0, 3, 0, 1, 1, 0, 1, 2, 0, 0, 8, 2, 5, 0);
    tbl_inst[2] = 32'h0020C863; tbl_exp[2] = mk(32'h308, 3, 4, 0, 1, 0, 0, 0, 0, 1, 0, 16, 1, 2, 0);
    tbl_inst[3] = 32'h000000EF; tbl_exp[3] = mk(32'h30C, 0, 6, 1, 0, 1, 0, 0, 0, 2, 0, 1, 0, 0, 0);
    tbl_inst[4] = 32'h123452B7; tbl_exp[4] = mk(32'h310, 10, 5, 1, 0, 1, 0, 0, 0, 0, 0, 5, 8, 3, 0);
    tbl_inst[5] = 32'h409453B3; tbl_exp[5] = mk(32'h314, 7, 1, 1, 1, 0, 0, 0, 0, 0, 0, 7, 8, 9, 0);
    for (int i = 0; i < 6; i++) begin
      drive(tbl_inst[i], 32'h300 + 32'(4 * i), 1'b1, tbl_exp[i]);
      tick();
      sb_check("table");
    end
    in_valid = 1'b0;

    // ebreak: bundle emitted, then HALT ignores input until resume
    drive(I_EBRK, 32'h400, 1'b1, mk(32'h400, 0, 2, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tick();
    sb_check("ebreak");
    chk("ebreak_halt", 67'(halt), 67'd1);
    chk("ebreak_in_ready", 67'(in_ready), 67'd0);
    drive(I_ADDI, 32'h404, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_hold", 67'({halt, out_valid}), 67'b10);
    end
    in_valid = 1'b0;
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk("resume_halt", 67'(halt), 67'd0);
    chk("resume_in_ready", 67'(in_ready), 67'd1);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk("resume_in_run", 67'(halt), 67'd0);

    // flush while halted with a held bundle
    out_ready = 1'b0;
    drive(I_EBRK, 32'h410, 1'b1, mk(32'h410, 0, 2, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tick();
    sb_check("ebreak2");
    in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_halt", 67'({halt, out_valid}), 67'b10);
    out_ready = 1'b1;
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk("flush_resume", 67'(halt), 67'd0);

    // flush during transfer discards lw, and an ebreak is not allowed to halt
    drive(I_LW, 32'h500, 1'b0, '0);
    flush = 1'b1;
    tick();
    chk("flush_lw", 67'({out_valid, halt, in_ready}), 67'b001);
    drive(I_EBRK, 32'h504, 1'b0, '0);
    tick();
    flush = 1'b0;
    chk("flush_ebreak", 67'({out_valid, halt}), 67'b00);
    drive(I_ADDI, 32'h508, 1'b1, mk(32'h508, 0, 2, 1, 1, 1, 0, 0, 0, 0, 0, 1, 2, 5, 0));
    tick();
    in_valid = 1'b0;
    sb_check("post_flush");

    // reset with a held bundle and a pending transfer
    out_ready = 1'b0;
    tick();
    chk("pre_rst_valid", 67'(out_valid), 67'd1);
    drive(I_LW, 32'h600, 1'b0, '0);
    rst = 1'b1;
    tick();
    chk("midrst_valid", 67'({out_valid, halt}), 67'b00);
    chk("midrst_bundle", obs, 67'd0);
`ifdef IDU_DECODE_PERF_EN
    chk("midrst_perf", 67'({perf_inst, perf_illegal}), 67'd0);
`endif
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("postrst_in_ready", 67'(in_ready), 67'd1);
    tick();
    chk("postrst_valid", 67'(out_valid), 67'd0);

`ifdef IDU_DECODE_PERF_EN
    drive(I_ADDI, 32'h700, 1'b1, mk(32'h700, 0, 2, 1, 1, 1, 0, 0, 0, 0, 0, 1, 2, 5, 0));
    tick();
    sb_check("perf_addi");
    drive(I_MUL, 32'h704, 1'b0, '0);
    tick();
    in_valid = 1'b0;
    chk("perf_inst", 67'(perf_inst), 67'd2);
    chk("perf_illegal", 67'(perf_illegal), 67'd1);
`endif

    chk("queue_drained", 67'(exp_q.size()), 67'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
